// File: rtl/core_mem_rd_initiator.sv
// DMA read initiator: splits byte-granular read requests into 16-byte beat commands and
// streams the in-order responses out as AXI-stream with per-request tkeep/tlast framing.
module core_mem_rd_initiator #(
    parameter int DATA_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 26,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 16,
    parameter int META_DEPTH      = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [LEN_WIDTH-1:0]      req_len,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic                      dma_cmd_rd_en,
    output logic [ADDR_WIDTH-1:0]     dma_cmd_rd_addr,
    output logic                      dma_cmd_rd_last,
    input  logic                      dma_cmd_rd_ready,
    input  logic                      dma_rd_resp_valid,
    input  logic [DATA_WIDTH-1:0]     dma_rd_resp_data,
    output logic                      dma_rd_resp_ready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(STRB_WIDTH);
    localparam int BEAT_W     = LEN_WIDTH - OFF_W + 1;
    localparam int SUM_W      = LEN_WIDTH + 1;
    localparam int CRED_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W      = $clog2(META_DEPTH);

    localparam logic [CRED_W-1:0]     CRED_MAX   = CRED_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W:0]        META_CAP   = (PTR_W + 1)'(META_DEPTH);
    localparam logic [BEAT_W-1:0]     ONE_BEAT   = BEAT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);

    typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

    typedef struct packed {
        logic [BEAT_W-1:0]     beats;
        logic [STRB_WIDTH-1:0] first_keep;
        logic [STRB_WIDTH-1:0] last_keep;
    } meta_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]     rem_q, rem_d;
    logic [CRED_W-1:0]     credit_q, credit_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic [BEAT_W-1:0]     rx_cnt_q, rx_cnt_d;

    meta_t                 meta_mem [META_DEPTH];
    meta_t                 meta_wdata, head;

    logic                  live, meta_empty, meta_full, meta_push, meta_pop;
    logic                  cmd_hs, axis_hs, head_last;

    logic [OFF_W-1:0]      req_off, end_off;
    logic [SUM_W-1:0]      span;
    logic [BEAT_W-1:0]     req_beats;
    logic [STRB_WIDTH-1:0] first_keep, last_keep;

    // Every control output is forced low while reset is held.
    assign live       = !sys_rst;
    assign meta_empty = (cnt_q == '0);
    assign meta_full  = (cnt_q == META_CAP);

    // Request decode: beat count and edge masks from the byte offset and length.
    always_comb begin
        req_off    = req_addr[OFF_W-1:0];
        span       = SUM_W'(req_off) + SUM_W'(req_len) + SUM_W'(STRB_WIDTH - 1);
        req_beats  = span[SUM_W-1:OFF_W];
        end_off    = req_off + req_len[OFF_W-1:0];
        first_keep = {STRB_WIDTH{1'b1}} << req_off;
        last_keep  = (end_off != '0) ? ~({STRB_WIDTH{1'b1}} << end_off) : {STRB_WIDTH{1'b1}};
        meta_wdata.beats      = req_beats;
        meta_wdata.first_keep = (req_beats == ONE_BEAT) ? (first_keep & last_keep) : first_keep;
        meta_wdata.last_keep  = last_keep;
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        req_ready       = 1'b0;
        dma_cmd_rd_en   = 1'b0;
        dma_cmd_rd_last = 1'b0;
        meta_push       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = live && !meta_full;
                if (req_valid && req_ready && (req_len != '0)) begin
                    addr_d    = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    rem_d     = req_beats;
                    meta_push = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dma_cmd_rd_en   = live && (credit_q < CRED_MAX);
                dma_cmd_rd_last = live && (rem_q == ONE_BEAT);
                if (dma_cmd_rd_en && dma_cmd_rd_ready) begin
                    addr_d = addr_q + BEAT_BYTES;
                    rem_d  = rem_q - ONE_BEAT;
                    if (rem_q == ONE_BEAT) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dma_cmd_rd_addr = addr_q;
    assign cmd_hs          = dma_cmd_rd_en && dma_cmd_rd_ready;

    // Response path is a straight pass-through; framing comes from the head meta entry.
    assign head              = meta_mem[rd_ptr_q];
    assign head_last         = (rx_cnt_q == (head.beats - ONE_BEAT));
    assign m_axis_tdata      = dma_rd_resp_data;
    assign m_axis_tvalid     = live && dma_rd_resp_valid && !meta_empty;
    assign dma_rd_resp_ready = live && m_axis_tready && !meta_empty;
    assign m_axis_tlast      = live && !meta_empty && head_last;
    assign axis_hs           = m_axis_tvalid && m_axis_tready;
    assign meta_pop          = axis_hs && head_last;

    always_comb begin
        if (rx_cnt_q == '0)  m_axis_tkeep = head.first_keep;
        else if (head_last)  m_axis_tkeep = head.last_keep;
        else                 m_axis_tkeep = {STRB_WIDTH{1'b1}};
    end

    always_comb begin
        credit_d = credit_q;
        unique case ({cmd_hs, axis_hs})
            2'b10:   credit_d = credit_q + CRED_W'(1);
            2'b01:   credit_d = credit_q - CRED_W'(1);
            default: credit_d = credit_q;
        endcase
        rx_cnt_d = rx_cnt_q;
        if (axis_hs) rx_cnt_d = head_last ? '0 : rx_cnt_q + ONE_BEAT;
        wr_ptr_d = wr_ptr_q + PTR_W'(meta_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(meta_pop);
        cnt_d    = cnt_q + (PTR_W + 1)'(meta_push) - (PTR_W + 1)'(meta_pop);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            credit_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            credit_q <= credit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Entries are only read between push and pop, so the storage needs no reset.
    always_ff @(posedge sys_clk) begin
        if (meta_push) meta_mem[wr_ptr_q] <= meta_wdata;
    end

endmodule

// File: tb/tb_core_mem_rd_initiator.sv
// Directed bench for core_mem_rd_initiator: a small in-order memory model answers commands,
// a monitor logs command and stream handshakes, and each test task checks the logs.
module tb_core_mem_rd_initiator;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [25:0]  req_addr = '0;
    logic [15:0]  req_len = '0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         dma_cmd_rd_en;
    logic [25:0]  dma_cmd_rd_addr;
    logic         dma_cmd_rd_last;
    logic         dma_cmd_rd_ready = 1'b0;
    logic         dma_rd_resp_valid = 1'b0;
    logic [127:0] dma_rd_resp_data = '0;
    logic         dma_rd_resp_ready;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;

    int checks = 0;
    int errors = 0;

    // 0: always, 1/2: stalled / random, 3: one-shot ready then stall
    int cmd_mode = 0;
    int tready_mode = 0;
    int resp_mode = 0;

    typedef struct { logic [25:0] addr; logic last; } cmd_t;
    typedef struct { logic [127:0] data; logic [15:0] keep; logic last; } beat_t;

    cmd_t        cmd_log[$];
    beat_t       beat_log[$];
    logic [25:0] pend[$];

    always #5 sys_clk = ~sys_clk;

    core_mem_rd_initiator dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
        .dma_cmd_rd_en(dma_cmd_rd_en), .dma_cmd_rd_addr(dma_cmd_rd_addr),
        .dma_cmd_rd_last(dma_cmd_rd_last), .dma_cmd_rd_ready(dma_cmd_rd_ready),
        .dma_rd_resp_valid(dma_rd_resp_valid), .dma_rd_resp_data(dma_rd_resp_data),
        .dma_rd_resp_ready(dma_rd_resp_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    function automatic logic [127:0] mkdata(input logic [25:0] a);
        logic [31:0] w;
        w = {6'b0, a};
        return {w ^ 32'hA5A5_0000, ~w, w + 32'h0000_1234, {w[15:0], w[31:16]}};
    endfunction

    function automatic int nbeats(input logic [25:0] a, input logic [15:0] l);
        return (int'(a[3:0]) + int'(l) + 15) / 16;
    endfunction

    function automatic logic [15:0] exp_keep(input logic [25:0] a, input logic [15:0] l,
                                             input int i, input int nb);
        logic [15:0] ones, k;
        int off, e;
        ones = 16'hFFFF;
        off  = int'(a[3:0]);
        e    = (off + int'(l)) % 16;
        k    = ones;
        if (i == 0) k = k & (ones << off);
        if (i == nb - 1 && e != 0) k = k & ~(ones << e);
        return k;
    endfunction

    // Memory model + monitor: drive at negedge, log the handshakes due at the next posedge.
    initial begin
        forever begin
            @(negedge sys_clk);
            dma_cmd_rd_ready = (cmd_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            case (tready_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'b0;
                2: m_axis_tready = 1'($urandom_range(0, 1));
                default: begin m_axis_tready = 1'b1; tready_mode = 1; end
            endcase
            if (pend.size() > 0) begin
                dma_rd_resp_valid = (resp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                dma_rd_resp_data  = mkdata(pend[0]);
            end else begin
                dma_rd_resp_valid = 1'b0;
                dma_rd_resp_data  = '0;
            end
            #1;
            if (sys_rst) begin
                pend.delete();
            end else begin
                if (dma_cmd_rd_en && dma_cmd_rd_ready) begin
                    pend.push_back(dma_cmd_rd_addr);
                    cmd_log.push_back('{dma_cmd_rd_addr, dma_cmd_rd_last});
                end
                if (m_axis_tvalid && m_axis_tready)
                    beat_log.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
                if (dma_rd_resp_valid && dma_rd_resp_ready && pend.size() > 0)
                    void'(pend.pop_front());
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
        #2;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_log.size() < n && k < 3000) begin
            @(negedge sys_clk);
            #2;
            k++;
        end
    endtask

    task automatic send_req(input logic [25:0] a, input logic [15:0] l);
        int n = 0;
        @(negedge sys_clk);
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        #2;
        while (!req_ready && n < 300) begin
            @(negedge sys_clk);
            #2;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_accept addr=%h got ready=%b exp 1", a, req_ready);
        end
        @(negedge sys_clk);
        req_valid = 1'b0;
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        beat_log.delete();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        wait_cycles(2);
        checks++;
        if ({req_ready, dma_cmd_rd_en, dma_cmd_rd_last, m_axis_tvalid, m_axis_tlast, dma_rd_resp_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000000",
                     {req_ready, dma_cmd_rd_en, dma_cmd_rd_last, m_axis_tvalid, m_axis_tlast, dma_rd_resp_ready});
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #2;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++;
        if (dut.credit_q !== 5'd0) begin errors++; $display("FAIL reset_credit got %0d exp 0", dut.credit_q); end
    endtask

    task automatic test_aligned();
        cmd_mode = 0; tready_mode = 0; resp_mode = 0;
        clear_logs();
        send_req(26'h100, 16'd64);
        wait_beats(4);
        wait_cycles(5);
        checks++;
        if (cmd_log.size() !== 4) begin errors++; $display("FAIL aligned_cmd_count got %0d exp 4", cmd_log.size()); end
        checks++;
        if (beat_log.size() !== 4) begin errors++; $display("FAIL aligned_beat_count got %0d exp 4", beat_log.size()); end
        for (int i = 0; i < 4 && i < cmd_log.size() && i < beat_log.size(); i++) begin
            checks++;
            if (cmd_log[i].addr !== 26'h100 + 26'(16 * i) || cmd_log[i].last !== (i == 3)) begin
                errors++;
                $display("FAIL aligned_cmd%0d got addr=%h last=%b exp addr=%h last=%b", i,
                         cmd_log[i].addr, cmd_log[i].last, 26'h100 + 26'(16 * i), (i == 3));
            end
            checks++;
            if (beat_log[i].keep !== 16'hFFFF || beat_log[i].last !== (i == 3) ||
                beat_log[i].data !== mkdata(26'h100 + 26'(16 * i))) begin
                errors++;
                $display("FAIL aligned_beat%0d got keep=%h last=%b exp keep=ffff last=%b", i,
                         beat_log[i].keep, beat_log[i].last, (i == 3));
            end
        end
    endtask

    task automatic test_unaligned();
        logic [15:0] ek[2];
        ek = '{16'hFFE0, 16'h01FF};
        cmd_mode = 0; tready_mode = 0; resp_mode = 0;
        clear_logs();
        send_req(26'h105, 16'd20);
        wait_beats(2);
        wait_cycles(5);
        checks++;
        if (cmd_log.size() !== 2 || beat_log.size() !== 2) begin
            errors++;
            $display("FAIL unaligned_counts got cmds=%0d beats=%0d exp 2/2", cmd_log.size(), beat_log.size());
        end
        for (int i = 0; i < 2 && i < cmd_log.size() && i < beat_log.size(); i++) begin
            checks++;
            if (cmd_log[i].addr !== 26'h100 + 26'(16 * i) || cmd_log[i].last !== (i == 1)) begin
                errors++;
                $display("FAIL unaligned_cmd%0d got addr=%h last=%b", i, cmd_log[i].addr, cmd_log[i].last);
            end
            checks++;
            if (beat_log[i].keep !== ek[i] || beat_log[i].last !== (i == 1)) begin
                errors++;
                $display("FAIL unaligned_beat%0d got keep=%h last=%b exp keep=%h last=%b", i,
                         beat_log[i].keep, beat_log[i].last, ek[i], (i == 1));
            end
        end
    endtask

    task automatic test_single_and_zero();
        cmd_mode = 0; tready_mode = 0; resp_mode = 0;
        clear_logs();
        send_req(26'h3, 16'd4);
        wait_beats(1);
        wait_cycles(4);
        checks++;
        if (cmd_log.size() !== 1 || beat_log.size() !== 1) begin
            errors++;
            $display("FAIL single_counts got cmds=%0d beats=%0d exp 1/1", cmd_log.size(), beat_log.size());
        end else begin
            checks++;
            if (cmd_log[0].addr !== 26'h0 || cmd_log[0].last !== 1'b1) begin
                errors++;
                $display("FAIL single_cmd got addr=%h last=%b exp 0/1", cmd_log[0].addr, cmd_log[0].last);
            end
            checks++;
            if (beat_log[0].keep !== 16'h0078 || beat_log[0].last !== 1'b1) begin
                errors++;
                $display("FAIL single_beat got keep=%h last=%b exp 0078/1", beat_log[0].keep, beat_log[0].last);
            end
        end
        clear_logs();
        send_req(26'h40, 16'd0);
        #2;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_len_ready got %b exp 1", req_ready); end
        wait_cycles(10);
        checks++;
        if (cmd_log.size() !== 0 || beat_log.size() !== 0) begin
            errors++;
            $display("FAIL zero_len_activity got cmds=%0d beats=%0d exp 0/0", cmd_log.size(), beat_log.size());
        end
    endtask

    task automatic test_credit();
        cmd_mode = 0; tready_mode = 1; resp_mode = 0;
        clear_logs();
        send_req(26'h0, 16'd512);
        wait_cycles(40);
        checks++;
        if (cmd_log.size() !== 16 || dma_cmd_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL credit_stall got cmds=%0d en=%b exp 16/0", cmd_log.size(), dma_cmd_rd_en);
        end
        checks++;
        if (dut.credit_q !== 5'd16) begin errors++; $display("FAIL credit_full got %0d exp 16", dut.credit_q); end
        tready_mode = 3;
        wait_cycles(10);
        checks++;
        if (cmd_log.size() !== 17 || beat_log.size() !== 1 || dma_cmd_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL credit_release got cmds=%0d beats=%0d en=%b exp 17/1/0",
                     cmd_log.size(), beat_log.size(), dma_cmd_rd_en);
        end
        tready_mode = 0;
        wait_beats(32);
        wait_cycles(5);
        checks++;
        if (cmd_log.size() !== 32 || beat_log.size() !== 32) begin
            errors++;
            $display("FAIL credit_drain got cmds=%0d beats=%0d exp 32/32", cmd_log.size(), beat_log.size());
        end else begin
            checks++;
            if (cmd_log[31].addr !== 26'h1F0 || cmd_log[31].last !== 1'b1 || cmd_log[30].last !== 1'b0 ||
                beat_log[31].last !== 1'b1 || beat_log[30].last !== 1'b0 ||
                beat_log[0].data !== mkdata(26'h0) || beat_log[31].data !== mkdata(26'h1F0)) begin
                errors++;
                $display("FAIL credit_tail got addr=%h cmdlast=%b beatlast=%b exp 1f0/1/1",
                         cmd_log[31].addr, cmd_log[31].last, beat_log[31].last);
            end
        end
    endtask

    task automatic test_wrap_and_backpressure();
        logic [25:0] ra[5];
        logic [15:0] rl[5];
        logic [25:0] ea[$];
        logic [15:0] ek[$];
        logic        el[$];
        cmd_mode = 0; tready_mode = 0; resp_mode = 0;
        clear_logs();
        send_req(26'h3FFFFF0, 16'd32);
        wait_beats(2);
        wait_cycles(4);
        checks++;
        if (cmd_log.size() !== 2) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 2", cmd_log.size());
        end else begin
            checks++;
            if (cmd_log[0].addr !== 26'h3FFFFF0 || cmd_log[1].addr !== 26'h0 || cmd_log[1].last !== 1'b1) begin
                errors++;
                $display("FAIL wrap_addr got %h %h exp 3fffff0 0000000", cmd_log[0].addr, cmd_log[1].addr);
            end
        end

        ra = '{26'h0000205, 26'h000003F, 26'h0000400, 26'h0000007, 26'h3FFFFE8};
        rl = '{16'd100, 16'd1, 16'd48, 16'd33, 16'd40};
        for (int r = 0; r < 5; r++) begin
            int nb;
            nb = nbeats(ra[r], rl[r]);
            for (int i = 0; i < nb; i++) begin
                ea.push_back((ra[r] & ~26'hF) + 26'(16 * i));
                ek.push_back(exp_keep(ra[r], rl[r], i, nb));
                el.push_back(i == nb - 1);
            end
        end
        cmd_mode = 2; tready_mode = 2; resp_mode = 2;
        clear_logs();
        for (int r = 0; r < 5; r++) send_req(ra[r], rl[r]);
        wait_beats(ea.size());
        wait_cycles(10);
        cmd_mode = 0; tready_mode = 0; resp_mode = 0;
        checks++;
        if (cmd_log.size() !== ea.size() || beat_log.size() !== ea.size()) begin
            errors++;
            $display("FAIL bp_counts got cmds=%0d beats=%0d exp %0d", cmd_log.size(), beat_log.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < cmd_log.size() && i < beat_log.size(); i++) begin
            checks++;
            if (cmd_log[i].addr !== ea[i] || beat_log[i].data !== mkdata(ea[i]) ||
                beat_log[i].keep !== ek[i] || beat_log[i].last !== el[i]) begin
                errors++;
                $display("FAIL bp_beat%0d got addr=%h keep=%h last=%b exp addr=%h keep=%h last=%b", i,
                         cmd_log[i].addr, beat_log[i].keep, beat_log[i].last, ea[i], ek[i], el[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int k = 0;
        cmd_mode = 0; tready_mode = 1; resp_mode = 0;
        clear_logs();
        send_req(26'h800, 16'd128);
        while (cmd_log.size() < 2 && k < 50) begin
            @(negedge sys_clk);
            #2;
            k++;
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        wait_cycles(1);
        checks++;
        if ({req_ready, dma_cmd_rd_en, dma_cmd_rd_last, m_axis_tvalid, m_axis_tlast, dma_rd_resp_ready} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %b exp 000000",
                     {req_ready, dma_cmd_rd_en, dma_cmd_rd_last, m_axis_tvalid, m_axis_tlast, dma_rd_resp_ready});
        end
        checks++;
        if (dut.credit_q !== 5'd0 || cmd_log.size() !== 2) begin
            errors++;
            $display("FAIL midrst_credit got credit=%0d cmds=%0d exp 0/2", dut.credit_q, cmd_log.size());
        end
        sys_rst = 1'b0;
        wait_cycles(1);
        checks++;
        if (req_ready !== 1'b1 || dma_cmd_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got ready=%b en=%b exp 1/0", req_ready, dma_cmd_rd_en);
        end
        tready_mode = 0;
        clear_logs();
        send_req(26'h40, 16'd40);
        wait_beats(3);
        wait_cycles(5);
        checks++;
        if (cmd_log.size() !== 3 || beat_log.size() !== 3) begin
            errors++;
            $display("FAIL midrst_fresh got cmds=%0d beats=%0d exp 3/3", cmd_log.size(), beat_log.size());
        end else begin
            checks++;
            if (beat_log[0].keep !== 16'hFFFF || beat_log[2].keep !== 16'h00FF || beat_log[2].last !== 1'b1 ||
                beat_log[1].last !== 1'b0 || beat_log[2].data !== mkdata(26'h60) || cmd_log[2].last !== 1'b1) begin
                errors++;
                $display("FAIL midrst_fresh_beats got keep0=%h keep2=%h last2=%b exp ffff/00ff/1",
                         beat_log[0].keep, beat_log[2].keep, beat_log[2].last);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_single_and_zero();
        test_credit();
        test_wrap_and_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
